// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the wait-state memory responder.
// Holds the FSM state encoding and the counter-load helper used by the top.
package mem_responder_pkg;

  localparam int DEFAULT_DEPTH       = 512;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int DATA_W              = 32;
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // The WAIT state starts one below the wait count because the edge
  // leaving IDLE already accounts for one of the inserted cycles.
  function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
    logic [CNT_W-1:0] load;
    if (wait_cycles == 0) begin
      load = '0;
    end else begin
      load = CNT_W'(wait_cycles - 1);
    end
    return load;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU datapath (MAR/MDR side) and the responder.
// MemError exists only when MEM_ERR_EN is defined.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic [DATA_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              Read;
  logic              Write;
  logic [DATA_W-1:0] Mdatain;
  logic              MemReady;
  logic              MemBusy;
`ifdef MEM_ERR_EN
  logic              MemError;
`endif

`ifdef MEM_ERR_EN
  modport master (
    output Address, WriteData, Read, Write,
    input  Mdatain, MemReady, MemBusy, MemError
  );

  modport slave (
    input  Address, WriteData, Read, Write,
    output Mdatain, MemReady, MemBusy, MemError
  );
`else
  modport master (
    output Address, WriteData, Read, Write,
    input  Mdatain, MemReady, MemBusy
  );

  modport slave (
    input  Address, WriteData, Read, Write,
    output Mdatain, MemReady, MemBusy
  );
`endif

endinterface

// File: rtl/mem_responder_mem_array.sv
// DEPTH x 32 storage with synchronous write and a registered, resettable read port.
// The storage itself is never reset; only the read register is.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ABITS = $clog2(DEFAULT_DEPTH)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ABITS-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] storage [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      storage[addr] <= wdata;
    end
  end

  // The read register only changes when a read completes, so it doubles
  // as the held response value seen by the requester.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_zero ? '0 : storage[addr];
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with WAIT_CYCLES wait states and a one-cycle MemReady pulse.
// Defining MEM_ERR_EN adds MemError for addresses beyond DEPTH words instead of wrapping.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic           clock,
  input  logic           clear,
  mem_responder_if.slave bus
);

  localparam int               ABITS    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ABITS-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              enter_respond;
  logic              mem_we;
  logic              mem_re;
  logic              mem_rzero;
  logic [DATA_W-1:0] mem_rdata;
  logic              req_err;

`ifdef MEM_ERR_EN
  logic err_q, err_d;
  logic error_q, error_d;

  assign req_err = |bus.Address[DATA_W-1:ABITS];
`else
  logic unused_addr_hi;

  assign req_err        = 1'b0;
  assign unused_addr_hi = |bus.Address[DATA_W-1:ABITS];
`endif

  // Next-state logic: the *_d request fields carry the live bus values on
  // the accepting edge so a zero-wait request can hit the array immediately.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    is_write_d    = is_write_q;
    enter_respond = 1'b0;
`ifdef MEM_ERR_EN
    err_d         = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.Read || bus.Write) begin
          addr_d     = bus.Address[ABITS-1:0];
          wdata_d    = bus.WriteData;
          is_write_d = bus.Write;
`ifdef MEM_ERR_EN
          err_d      = req_err;
`endif
          if (WAIT_CYCLES == 0) begin
            state_d       = RESPOND;
            cnt_d         = '0;
            enter_respond = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          state_d       = RESPOND;
          enter_respond = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESPOND: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = enter_respond;
`ifdef MEM_ERR_EN
    error_d = enter_respond && err_d;
`endif
  end

  // Array strobes fire on the RESPOND-entry edge; the write is gated by
  // clear so an asserted reset can never land a store.
`ifdef MEM_ERR_EN
  assign mem_we    = enter_respond && is_write_d && !err_d && clear;
  assign mem_rzero = err_d;
`else
  assign mem_we    = enter_respond && is_write_d && clear;
  assign mem_rzero = req_err;
`endif
  assign mem_re = enter_respond && !is_write_d;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MEM_ERR_EN
      err_q      <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef MEM_ERR_EN
      err_q      <= err_d;
      error_q    <= error_d;
`endif
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .ABITS (ABITS)
  ) u_mem_array (
    .clock   (clock),
    .clear   (clear),
    .wr_en   (mem_we),
    .rd_en   (mem_re),
    .rd_zero (mem_rzero),
    .addr    (addr_d),
    .wdata   (wdata_d),
    .rdata   (mem_rdata)
  );

  assign bus.Mdatain  = mem_rdata;
  assign bus.MemReady = ready_q;
  assign bus.MemBusy  = busy_q;
`ifdef MEM_ERR_EN
  assign bus.MemError = error_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a WAIT_CYCLES=2 instance and a zero-wait instance.
// Builds with or without MEM_ERR_EN.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int          DEPTH   = 512;
  localparam int          WC_A    = 2;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
`ifdef MEM_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] waitAddr;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   passCount  = 0;
  int   totalCount = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] modelLast;
  vec_t        vecs [12];

  mem_responder_if ifA ();
  mem_responder_if ifB ();

  mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WC_A)
  ) u_dutA (
    .clock (clock),
    .clear (clear),
    .bus   (ifA.slave)
  );

  mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (0)
  ) u_dutB (
    .clock (clock),
    .clear (clear),
    .bus   (ifB.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Behavioural reference: word array indexed modulo DEPTH, last read value,
  // out-of-range addresses flagged only in the error build.
  function automatic void modelStep(input logic rd, input logic wr, input logic [31:0] addr,
                                    input logic [31:0] data, output logic [31:0] expData,
                                    output logic expErr);
    logic [31:0] idx;
    logic        err;
    idx = addr % DEPTH_U;
    err = 1'b0;
`ifdef MEM_ERR_EN
    err = (addr / DEPTH_U) != 32'd0;
`endif
    if (wr) begin
      if (!err) model[idx] = data;
    end else if (rd) begin
      modelLast = err ? 32'h0 : model[idx];
    end
    expData = modelLast;
    expErr  = err;
  endfunction

  // One request on instance A; junk is driven on the bus during the wait.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] waitAddr, input logic [31:0] expData,
                               input logic expErr);
    int lat;
    @(negedge clock);
    ifA.Read      = rd;
    ifA.Write     = wr;
    ifA.Address   = addr;
    ifA.WriteData = data;
    @(negedge clock);
    checkOutput({name, " busy"}, {31'b0, ifA.MemBusy}, 32'h1);
    lat = 1;
    while (!ifA.MemReady && lat < 40) begin
      ifA.Address   = waitAddr;
      ifA.WriteData = $urandom;
      ifA.Read      = 1'($urandom_range(0, 1));
      ifA.Write     = 1'($urandom_range(0, 1));
      @(negedge clock);
      lat++;
    end
    ifA.Read  = 1'b0;
    ifA.Write = 1'b0;
    checkOutput({name, " latency"}, 32'(lat), 32'(WC_A + 1));
    checkOutput({name, " ready"}, {31'b0, ifA.MemReady}, 32'h1);
    checkOutput({name, " data"}, ifA.Mdatain, expData);
`ifdef MEM_ERR_EN
    checkOutput({name, " error"}, {31'b0, ifA.MemError}, {31'b0, expErr});
`else
    if (expErr) $display("[TB] note: error expectation ignored without MEM_ERR_EN");
`endif
    @(negedge clock);
    checkOutput({name, " ready drop"}, {31'b0, ifA.MemReady}, 32'h0);
    checkOutput({name, " idle busy"}, {31'b0, ifA.MemBusy}, 32'h0);
    checkOutput({name, " data held"}, ifA.Mdatain, expData);
  endtask

  initial begin
    logic [31:0] eData;
    logic        eErr;
    logic [31:0] rAddr;
    logic [31:0] rData;
    int          op;

    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    modelLast = 32'h0;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h1FF, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'h1FF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h5,   32'h00001234, 32'h1FF, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h5,   32'h0,        32'h1FF, 32'h00001234, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0,   32'hA0A0A0A0, 32'h1FF, 32'h00001234, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h200, 32'h00000055, 32'h1FF, 32'h00001234, ERR_BUILD};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h1FF, ERR_BUILD ? 32'hA0A0A0A0 : 32'h55, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h1FF, ERR_BUILD ? 32'h0 : 32'h55, ERR_BUILD};
    vecs[8]  = '{1'b0, 1'b1, 32'h8,   32'h00008888, 32'h1FF, ERR_BUILD ? 32'h0 : 32'h55, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h9,   32'h00009999, 32'h1FF, ERR_BUILD ? 32'h0 : 32'h55, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h9,   32'h00008888, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h20,  32'hCAFEF00D, 32'h1FF, 32'h00008888, 1'b0};

    ifA.Read = 1'b0; ifA.Write = 1'b0; ifA.Address = '0; ifA.WriteData = '0;
    ifB.Read = 1'b0; ifB.Write = 1'b0; ifB.Address = '0; ifB.WriteData = '0;

    #1 clear = 1'b0;
    #2;
    checkOutput("reset A data",  ifA.Mdatain, 32'h0);
    checkOutput("reset A ready", {31'b0, ifA.MemReady}, 32'h0);
    checkOutput("reset A busy",  {31'b0, ifA.MemBusy}, 32'h0);
    checkOutput("reset B busy",  {31'b0, ifB.MemBusy}, 32'h0);
    @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < 12; i++) begin
      modelStep(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, eData, eErr);
      applyStimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].data, vecs[i].waitAddr, vecs[i].expData, vecs[i].expErr);
    end

    // Reset in WAIT aborts the write to 0x20 and zeroes outputs at once.
    @(negedge clock);
    ifA.Write = 1'b1; ifA.Address = 32'h20; ifA.WriteData = 32'h11112222;
    @(negedge clock);
    ifA.Write = 1'b0;
    checkOutput("abort busy before", {31'b0, ifA.MemBusy}, 32'h1);
    #1 clear = 1'b0;
    #1;
    checkOutput("abort data",  ifA.Mdatain, 32'h0);
    checkOutput("abort ready", {31'b0, ifA.MemReady}, 32'h0);
    checkOutput("abort busy",  {31'b0, ifA.MemBusy}, 32'h0);
`ifdef MEM_ERR_EN
    checkOutput("abort error", {31'b0, ifA.MemError}, 32'h0);
`endif
    modelLast = 32'h0;
    @(negedge clock);
    clear = 1'b1;
    modelStep(1'b1, 1'b0, 32'h20, 32'h0, eData, eErr);
    applyStimulus("after abort", 1'b1, 1'b0, 32'h20, 32'h0, 32'h1FF, 32'hCAFEF00D, 1'b0);

    // Zero-wait instance: single write, then a held read strobe.
    @(negedge clock);
    ifB.Write = 1'b1; ifB.Address = 32'h3; ifB.WriteData = 32'h33333333;
    @(negedge clock);
    ifB.Write = 1'b0;
    checkOutput("B write ready", {31'b0, ifB.MemReady}, 32'h1);
    checkOutput("B write busy",  {31'b0, ifB.MemBusy}, 32'h1);
    @(negedge clock);
    checkOutput("B write drop",  {31'b0, ifB.MemReady}, 32'h0);
    ifB.Read = 1'b1; ifB.Address = 32'h3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput($sformatf("B held ready %0d", i), {31'b0, ifB.MemReady}, {31'b0, (i % 2) == 0});
      checkOutput($sformatf("B held busy %0d", i),  {31'b0, ifB.MemBusy},  {31'b0, (i % 2) == 0});
      if ((i % 2) == 0) checkOutput($sformatf("B held data %0d", i), ifB.Mdatain, 32'h33333333);
    end
    ifB.Read = 1'b0;

    // Randomized traffic on instance A against the reference model.
    for (int a = 0; a < 16; a++) begin
      rData = $urandom;
      modelStep(1'b0, 1'b1, 32'(a), rData, eData, eErr);
      applyStimulus($sformatf("fill%0d", a), 1'b0, 1'b1, 32'(a), rData, $urandom, eData, eErr);
    end
    for (int n = 0; n < 40; n++) begin
      op    = $urandom_range(0, 2);
      rAddr = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rAddr = rAddr | (32'($urandom_range(1, 255)) << 9);
      rData = $urandom;
      modelStep(op != 1, op != 0, rAddr, rData, eData, eErr);
      applyStimulus($sformatf("rand%0d", n), op != 1, op != 0, rAddr, rData, $urandom, eData, eErr);
    end

    repeat (2) @(negedge clock);
    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of 32-bit words; power of two; ABITS = log2(DEPTH).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response; range 0..15.
REQ-003 SHALL have port clock  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port Address  in  32: word address driven from MAR.
REQ-006 SHALL have port WriteData  in  32: store data driven from MDR.
REQ-007 SHALL have port Read  in  1: read request strobe.
REQ-008 SHALL have port Write  in  1: write request strobe.
REQ-009 SHALL have port Mdatain  out  32: read data returned to the MDR input.
REQ-010 SHALL have port MemReady  out  1: one-cycle completion pulse.
REQ-011 SHALL have port MemBusy  out  1: high while a request is in flight.
REQ-012 SHALL have port MemError  out  1: address-range error pulse; present only under MEM_ERR_EN.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-014 IDLE: Read or Write high at an edge SHALL accept the request and latch Address[ABITS-1:0], WriteData and op; next state WAIT, or RESPOND if WAIT_CYCLES=0.
REQ-015 Read and Write both high at accept SHALL be treated as a write; the read is dropped.
REQ-016 WAIT SHALL load the counter with WAIT_CYCLES-1 on entry, decrement each cycle, and go to RESPOND on the edge where it equals 0.
REQ-017 Write data SHALL be stored on the edge entering RESPOND; for a read, the addressed word SHALL be loaded into Mdatain on that same edge.
REQ-018 Latency: request accepted at edge k SHALL give MemReady=1 during cycle k+WAIT_CYCLES+1, for exactly one cycle.
REQ-019 Mdatain SHALL hold the last read value until the next read completes; writes SHALL leave it unchanged.
REQ-020 RESPOND SHALL always go to IDLE; a strobe still high in IDLE SHALL be accepted as a new request, so the requester drops the strobe on MemReady.
REQ-021 Address, WriteData and strobe changes while in WAIT or RESPOND SHALL be ignored.
REQ-022 MemBusy SHALL be 1 in WAIT and RESPOND and 0 in IDLE.
REQ-023 Address bits above ABITS SHALL be ignored, so addresses wrap modulo DEPTH (without the macro).

Reset
REQ-024 clear=0 SHALL immediately force: state IDLE, counter 0, Mdatain 0, MemReady 0, MemBusy 0, MemError 0.
REQ-025 Reset before the RESPOND-entry edge SHALL abort the request, leaving memory unchanged.
REQ-026 Storage contents SHALL NOT be reset.

Configuration
REQ-027 With MEM_ERR_EN defined, any nonzero Address[31:ABITS] at accept SHALL:
- pulse MemError together with MemReady;
- suppress the write;
- return Mdatain = 0 for a read.
REQ-028 Without MEM_ERR_EN, the MemError port and its logic SHALL be absent, and REQ-023 wrapping applies.

Structure
REQ-029 Package mem_responder_pkg SHALL hold the state enum (IDLE/WAIT/RESPOND) and the DEPTH/WAIT_CYCLES default constants.
REQ-030 Storage SHALL be sub-module mem_array: DEPTH x 32, synchronous write, registered read, addressed by the latched address.

Verification
REQ-031 The bench SHALL cover write-then-read: WAIT_CYCLES=2, Write 0xDEADBEEF to 0x10 accepted at edge k -> MemReady in cycle k+3; a following read of 0x10 -> Mdatain=0xDEADBEEF with MemReady.
REQ-032 The bench SHALL cover simultaneous strobes: Read=Write=1, Address 5, data 0x00001234 -> write performed, Mdatain unchanged; a later read of 5 -> 0x00001234.
REQ-033 The bench SHALL cover wrap and error at DEPTH=512: write 0x55 to Address 0x200.
- Without MEM_ERR_EN: a read of 0 returns 0x55.
- With MEM_ERR_EN: MemError=1 with MemReady, and word 0 is unchanged.
REQ-034 The bench SHALL cover zero wait and held strobe: WAIT_CYCLES=0, Read held high -> MemReady every 2nd cycle, MemBusy toggling 0/1.
REQ-035 The bench SHALL cover reset mid-operation: clear=0 during WAIT of a write to 0x20 -> all outputs 0 at once; a later read of 0x20 returns the prior contents.
REQ-036 The bench SHALL cover input changes during WAIT: change Address from 0x8 to 0x9 while in WAIT -> the response reflects word 0x8.
